// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the MEM-stage CPU port and a debug/loader port.
// Issue is combinational (0 cycles); read data returns one cycle later; CPU loads stall one cycle and starved debug requests are force-granted.
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_i,
   input  logic              start_i,
   input  logic              cpu_rd_i,
   input  logic              cpu_wr_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_wdata_i,
   output logic [DATA_W-1:0] cpu_rdata_o,
   output logic              cpu_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic              dbg_gnt_o,
   output logic              dbg_rvalid_o,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [31:0]       stall_cnt_o
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, CPU_RD, DBG_RD} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dbg_rdata;
   logic [31:0]       r_stall_cnt;

   logic w_cpu_elig;
   logic w_dbg_force;
   logic w_dbg_issue;
   logic w_cpu_issue;

   // While in CPU_RD the still-held CPU request is the one already served.
   always_comb begin
      w_cpu_elig  = (cpu_rd_i | cpu_wr_i) && (r_state != CPU_RD);
      w_dbg_force = dbg_req_i && (r_starve_cnt >= STARVE_LIM);
      w_dbg_issue = start_i && (w_dbg_force || (dbg_req_i && !w_cpu_elig));
      w_cpu_issue = start_i && w_cpu_elig && !w_dbg_force;
   end

   always_comb begin
      mem_en_o     = w_dbg_issue | w_cpu_issue;
      mem_we_o     = w_dbg_issue ? dbg_we_i    : (w_cpu_issue & cpu_wr_i);
      mem_addr_o   = w_dbg_issue ? dbg_addr_i  : cpu_addr_i;
      mem_wdata_o  = w_dbg_issue ? dbg_wdata_i : cpu_wdata_i;
      dbg_gnt_o    = w_dbg_issue;
      cpu_stall_o  = start_i && ((w_cpu_issue && cpu_rd_i) || (w_cpu_elig && !w_cpu_issue));
      cpu_rdata_o  = (r_state == CPU_RD) ? mem_rdata_i : r_cpu_rdata;
      // Debug data is valid during the return cycle itself, i.e. grant+1.
      dbg_rdata_o  = (r_state == DBG_RD) ? mem_rdata_i : r_dbg_rdata;
      dbg_rvalid_o = (r_state == DBG_RD);
      stall_cnt_o  = r_stall_cnt;
   end

   always_ff @(posedge clk_i or negedge start_i) begin
      if (!start_i) begin
         r_state      <= IDLE;
         r_starve_cnt <= '0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_cpu_issue && cpu_rd_i)
            r_state <= CPU_RD;
         else if (w_dbg_issue && !dbg_we_i)
            r_state <= DBG_RD;
         else
            r_state <= IDLE;

         if (r_state == CPU_RD)
            r_cpu_rdata <= mem_rdata_i;
         if (r_state == DBG_RD)
            r_dbg_rdata <= mem_rdata_i;

         if (!dbg_req_i || w_dbg_issue)
            r_starve_cnt <= '0;
         else if (r_starve_cnt < STARVE_LIM)
            r_starve_cnt <= r_starve_cnt + 1'b1;

         if (cpu_stall_o && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory with registered read, scoreboard queues for returned read data.
module tb_dmem_arbiter;

   logic        clk;
   logic        start_i;
   logic        cpu_rd, cpu_wr;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata_o;
   logic        cpu_stall_o;
   logic        dbg_req, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata;
   logic        dbg_gnt_o, dbg_rvalid_o;
   logic [31:0] dbg_rdata_o;
   logic        mem_en_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_wdata_o;
   logic [31:0] mem_rdata;
   logic [31:0] stall_cnt_o;

   logic [31:0] mem_model [0:255];
   logic [31:0] exp_cpu[$];
   logic [31:0] exp_dbg[$];
   logic [31:0] exp;
   int vectors;
   int miscompares;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
      .clk_i(clk), .start_i(start_i),
      .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
      .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o), .dbg_rdata_o(dbg_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata), .stall_cnt_o(stall_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en_o) begin
         if (mem_we_o) mem_model[mem_addr_o[9:2]] <= mem_wdata_o;
         else          mem_rdata <= mem_model[mem_addr_o[9:2]];
      end
   end

   task automatic idle_inputs();
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   task automatic do_reset();
      @(negedge clk); idle_inputs(); start_i = 1'b0;
      @(negedge clk); start_i = 1'b1;
      exp_cpu.delete(); exp_dbg.delete();
   endtask

   task automatic dbg_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
      @(negedge clk); idle_inputs();
   endtask

   task automatic test_reset();
      @(negedge clk); start_i = 1'b0; cpu_rd = 1'b1; dbg_req = 1'b1; #1;
      vectors++; if (mem_en_o !== 1'b0) begin miscompares++; $display("FAIL rst_mem_en: got %b want 0", mem_en_o); end
      vectors++; if (dbg_gnt_o !== 1'b0) begin miscompares++; $display("FAIL rst_gnt: got %b want 0", dbg_gnt_o); end
      vectors++; if (cpu_stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", cpu_stall_o); end
      vectors++; if (dbg_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid: got %b want 0", dbg_rvalid_o); end
      vectors++; if (cpu_rdata_o !== 32'h0) begin miscompares++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_rdata_o); end
      vectors++; if (dbg_rdata_o !== 32'h0) begin miscompares++; $display("FAIL rst_dbg_rdata: got %h want 0", dbg_rdata_o); end
      vectors++; if (stall_cnt_o !== 32'h0) begin miscompares++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt_o); end
      idle_inputs(); start_i = 1'b1;
   endtask

   task automatic test_store_load();
      do_reset();
      @(negedge clk); cpu_wr = 1'b1; cpu_addr = 32'h4; cpu_wdata = 32'h5; #1;
      vectors++; if ({mem_en_o, mem_we_o, cpu_stall_o} !== 3'b110) begin miscompares++; $display("FAIL st_issue: got en/we/stall %b want 110", {mem_en_o, mem_we_o, cpu_stall_o}); end
      @(negedge clk); cpu_wr = 1'b0; cpu_rd = 1'b1; exp_cpu.push_back(32'h5); #1;
      vectors++; if ({mem_en_o, mem_we_o, cpu_stall_o} !== 3'b101) begin miscompares++; $display("FAIL ld_issue: got en/we/stall %b want 101", {mem_en_o, mem_we_o, cpu_stall_o}); end
      @(negedge clk); #1;
      exp = exp_cpu.pop_front();
      vectors++; if (cpu_stall_o !== 1'b0) begin miscompares++; $display("FAIL ld_release: got stall %b want 0", cpu_stall_o); end
      vectors++; if (cpu_rdata_o !== exp) begin miscompares++; $display("FAIL ld_data: got %h want %h", cpu_rdata_o, exp); end
      @(negedge clk); idle_inputs(); #1;
      vectors++; if (cpu_rdata_o !== exp) begin miscompares++; $display("FAIL ld_hold: got %h want %h", cpu_rdata_o, exp); end
      vectors++; if (stall_cnt_o !== 32'd1) begin miscompares++; $display("FAIL ld_stall_cnt: got %0d want 1", stall_cnt_o); end
   endtask

   task automatic test_dbg_rw();
      do_reset();
      @(negedge clk); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8; dbg_wdata = 32'hDEADBEEF; #1;
      vectors++; if ({dbg_gnt_o, mem_we_o} !== 2'b11) begin miscompares++; $display("FAIL dbg_wr_gnt: got gnt/we %b want 11", {dbg_gnt_o, mem_we_o}); end
      @(negedge clk); dbg_we = 1'b0; exp_dbg.push_back(32'hDEADBEEF); #1;
      vectors++; if ({dbg_gnt_o, mem_we_o} !== 2'b10) begin miscompares++; $display("FAIL dbg_rd_gnt: got gnt/we %b want 10", {dbg_gnt_o, mem_we_o}); end
      @(negedge clk); idle_inputs(); #1;
      exp = exp_dbg.pop_front();
      vectors++; if (dbg_rvalid_o !== 1'b1) begin miscompares++; $display("FAIL dbg_rvalid: got %b want 1", dbg_rvalid_o); end
      vectors++; if (dbg_rdata_o !== exp) begin miscompares++; $display("FAIL dbg_rdata: got %h want %h", dbg_rdata_o, exp); end
      @(negedge clk); #1;
      vectors++; if (dbg_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL dbg_rvalid_pulse: got %b want 0", dbg_rvalid_o); end
   endtask

   task automatic test_starvation();
      int k;
      logic exp_g;
      logic granted;
      do_reset();
      k = 0; granted = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         cpu_wr = 1'b1; cpu_addr = 32'h100 + 4 * k; cpu_wdata = 32'h5000 + k;
         dbg_req = !granted; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'hAA;
         #1;
         exp_g = (c == 4);
         vectors++; if (dbg_gnt_o !== exp_g) begin miscompares++; $display("FAIL starve_gnt c%0d: got %b want %b", c, dbg_gnt_o, exp_g); end
         vectors++; if (cpu_stall_o !== exp_g) begin miscompares++; $display("FAIL starve_stall c%0d: got %b want %b", c, cpu_stall_o, exp_g); end
         if (exp_g) granted = 1'b1;
         else k++;
      end
      @(negedge clk); idle_inputs(); #1;
      vectors++; if (stall_cnt_o !== 32'd1) begin miscompares++; $display("FAIL starve_stall_cnt: got %0d want 1", stall_cnt_o); end
      vectors++; if (mem_model[8'h80] !== 32'hAA) begin miscompares++; $display("FAIL starve_dbg_mem: got %h want 000000aa", mem_model[8'h80]); end
      vectors++; if (mem_model[8'h44] !== 32'h5004) begin miscompares++; $display("FAIL starve_cpu_mem: got %h want 00005004", mem_model[8'h44]); end
   endtask

   task automatic test_dbg_during_cpu_rd();
      do_reset();
      dbg_write(32'h40, 32'h11111111);
      dbg_write(32'h44, 32'h22222222);
      @(negedge clk); cpu_rd = 1'b1; cpu_addr = 32'h40; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
      exp_cpu.push_back(32'h11111111); #1;
      vectors++; if ({cpu_stall_o, dbg_gnt_o} !== 2'b10) begin miscompares++; $display("FAIL ovl_issue: got stall/gnt %b want 10", {cpu_stall_o, dbg_gnt_o}); end
      @(negedge clk); exp_dbg.push_back(32'h22222222); #1;
      exp = exp_cpu.pop_front();
      vectors++; if ({cpu_stall_o, dbg_gnt_o} !== 2'b01) begin miscompares++; $display("FAIL ovl_cpurd: got stall/gnt %b want 01", {cpu_stall_o, dbg_gnt_o}); end
      vectors++; if (cpu_rdata_o !== exp) begin miscompares++; $display("FAIL ovl_cpu_data: got %h want %h", cpu_rdata_o, exp); end
      @(negedge clk); idle_inputs(); #1;
      exp = exp_dbg.pop_front();
      vectors++; if (dbg_rvalid_o !== 1'b1) begin miscompares++; $display("FAIL ovl_rvalid: got %b want 1", dbg_rvalid_o); end
      vectors++; if (dbg_rdata_o !== exp) begin miscompares++; $display("FAIL ovl_dbg_data: got %h want %h", dbg_rdata_o, exp); end
      vectors++; if (stall_cnt_o !== 32'd1) begin miscompares++; $display("FAIL ovl_stall_cnt: got %0d want 1", stall_cnt_o); end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      dbg_write(32'h50, 32'h33);
      @(negedge clk); cpu_rd = 1'b1; cpu_addr = 32'h50; #1;
      vectors++; if (cpu_stall_o !== 1'b1) begin miscompares++; $display("FAIL mid_issue: got stall %b want 1", cpu_stall_o); end
      @(negedge clk); start_i = 1'b0; #1;
      vectors++; if (cpu_rdata_o !== 32'h0) begin miscompares++; $display("FAIL mid_cpu_rdata: got %h want 0", cpu_rdata_o); end
      vectors++; if ({mem_en_o, cpu_stall_o, dbg_rvalid_o} !== 3'b000) begin miscompares++; $display("FAIL mid_outs: got en/stall/rvalid %b want 000", {mem_en_o, cpu_stall_o, dbg_rvalid_o}); end
      vectors++; if (stall_cnt_o !== 32'h0) begin miscompares++; $display("FAIL mid_stall_cnt: got %0d want 0", stall_cnt_o); end
      @(negedge clk); idle_inputs(); start_i = 1'b1;
      @(negedge clk); #1;
      vectors++; if ({cpu_rdata_o, dbg_rvalid_o} !== 33'h0) begin miscompares++; $display("FAIL mid_after: got rdata %h rvalid %b want 0/0", cpu_rdata_o, dbg_rvalid_o); end
      vectors++; if (stall_cnt_o !== 32'h0) begin miscompares++; $display("FAIL mid_after_cnt: got %0d want 0", stall_cnt_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      dbg_write(32'h0, 32'hA0A0A0A0);
      dbg_write(32'h4, 32'hA4A4A4A4);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); cpu_rd = 1'b1; cpu_addr = 32'(4 * i);
         exp_cpu.push_back(i == 0 ? 32'hA0A0A0A0 : 32'hA4A4A4A4); #1;
         vectors++; if (cpu_stall_o !== 1'b1) begin miscompares++; $display("FAIL b2b_stall%0d: got %b want 1", i, cpu_stall_o); end
         @(negedge clk); #1;
         exp = exp_cpu.pop_front();
         vectors++; if (cpu_stall_o !== 1'b0) begin miscompares++; $display("FAIL b2b_release%0d: got %b want 0", i, cpu_stall_o); end
         vectors++; if (cpu_rdata_o !== exp) begin miscompares++; $display("FAIL b2b_data%0d: got %h want %h", i, cpu_rdata_o, exp); end
      end
      @(negedge clk); idle_inputs(); #1;
      vectors++; if (stall_cnt_o !== 32'd2) begin miscompares++; $display("FAIL b2b_stall_cnt: got %0d want 2", stall_cnt_o); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors = 0; miscompares = 0;
      start_i = 1'b0; mem_rdata = '0;
      idle_inputs();
      repeat (2) @(negedge clk);
      test_reset();
      test_store_load();
      test_dbg_rw();
      test_starvation();
      test_dbg_during_cpu_rd();
      test_reset_mid_read();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
